// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative partial-product multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_iter(input int width, input int k);
    return width / k;
  endfunction

  // A one-iteration multiplier still needs a 1-bit counter to keep the port legal.
  function automatic int ctr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit slice_cfg_ok(input int width, input int k);
    return (width >= 2) && (k >= 1) && (k <= width) && ((width % k) == 0);
  endfunction

endpackage

// File: rtl/pp_column_adder.sv
// Combinational slice stage: K partial products of the multiplicand, summed into a
// (WIDTH+K)-bit slice result.
module pp_column_adder #(
  parameter int WIDTH = 8,
  parameter int K     = 2
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [K-1:0]       b_slice,
  output logic [WIDTH+K-1:0] sum
);

  logic [WIDTH+K-1:0] pp_shifted [K];

  for (genvar gi = 0; gi < K; gi++) begin : g_pp
    assign pp_shifted[gi] = (WIDTH+K)'(a & {WIDTH{b_slice[gi]}}) << gi;
  end

  // (2^W-1)*(2^K-1) fits in WIDTH+K bits, so the running sum never truncates.
  always_comb begin
    sum = '0;
    for (int j = 0; j < K; j++) begin
      sum = sum + pp_shifted[j];
    end
  end

endmodule

// File: rtl/seq_pp_multiplier.sv
// Iterative unsigned multiplier consuming BITS_PER_CYCLE multiplier bits per cycle.
// Optional self-check against a behavioural product: define MULT_SELFCHECK_EN.
module seq_pp_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               err
);

  localparam int K        = BITS_PER_CYCLE;
  localparam int NUM_ITER = num_iter(WIDTH, K);
  localparam int CW       = ctr_width(NUM_ITER);
  localparam int AW       = 2 * WIDTH;
  localparam int SW       = WIDTH + K;

  if (!slice_cfg_ok(WIDTH, K)) begin : g_bad_cfg
    $error("seq_pp_multiplier: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    ctr_q, ctr_d;
  logic [K-1:0]     b_slice;
  logic [SW-1:0]    slice_sum;
  logic             last_iter;

  assign b_slice   = b_q[int'(ctr_q)*K +: K];
  assign last_iter = (ctr_q == CW'(NUM_ITER - 1));

  pp_column_adder #(
    .WIDTH (WIDTH),
    .K     (K)
  ) u_pp_column_adder (
    .a       (a_q),
    .b_slice (b_slice),
    .sum     (slice_sum)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    ctr_d     = ctr_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    p         = '0;
    case (state_q)
      IDLE: begin
        // Held low while rst is asserted so nothing is accepted in the reset cycle.
        in_ready = !rst;
        if (in_valid && !rst) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          ctr_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        acc_d = acc_q + (AW'(slice_sum) << (int'(ctr_q) * K));
        if (last_iter) begin
          state_d = DONE;
        end else begin
          ctr_d = ctr_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        p         = acc_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ctr_q   <= ctr_d;
    end
  end

`ifdef MULT_SELFCHECK_EN
  logic err_q, err_d;

  // Evaluated on the final BUSY cycle, i.e. against the value entering DONE.
  always_comb begin
    err_d = err_q;
    if ((state_q == BUSY) && last_iter && (acc_d != (AW'(a_q) * AW'(b_q)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pp_multiplier.sv
// Directed-vector bench for seq_pp_multiplier (WIDTH=8, K=2) plus a K sweep over 1/2/4/8.
module tb_seq_pp_multiplier;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    int          hold;
  } vec_t;

  localparam int NVEC    = 8;
  localparam int SWEEP_N = 200;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic [3:0]  s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_err;
  logic [15:0] s_p [4];

  int n_cmp;
  int n_fail;

  vec_t vecs [NVEC];

  seq_pp_multiplier #(
    .WIDTH          (8),
    .BITS_PER_CYCLE (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy),
    .err       (err)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
    seq_pp_multiplier #(
      .WIDTH          (8),
      .BITS_PER_CYCLE (1 << gi)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_in_valid[gi]),
      .in_ready  (s_in_ready[gi]),
      .a         (a),
      .b         (b),
      .out_valid (s_out_valid[gi]),
      .out_ready (s_out_ready[gi]),
      .p         (s_p[gi]),
      .busy      (s_busy[gi]),
      .err       (s_err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [7:0] ta, input logic [7:0] tb_b,
                         input logic [15:0] want, input int hold);
    int lat, busy_cnt, guard;
    logic rdy_low, p_stable;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    a = ta;
    b = tb_b;
    in_valid = 1'b1;
    tick();
    // Keep presenting different operands; they must be ignored until the next IDLE.
    a = ~ta;
    b = ~tb_b;
    lat = 0;
    busy_cnt = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      if (in_ready) rdy_low = 1'b0;
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    check("busy_cycles", 32'(busy_cnt), 32'd4);
    check("p", 32'(p), 32'(want));
    check("err_clear", 32'(err), 32'd0);
    p_stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (!out_valid || p !== want || in_ready) p_stable = 1'b0;
      tick();
    end
    if (hold > 0) check("hold_stable", 32'(p_stable && out_valid && !in_ready), 32'd1);
    check("in_ready_low", 32'(rdy_low && !in_ready), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    $display("txn a=0x%02h b=0x%02h p=0x%04h want=0x%04h lat=%0d hold=%0d", ta, tb_b, p, want, lat, hold);
  endtask

  task automatic sweep(input int k);
    int lat;
    logic [15:0] want;
    int fails_before;
    fails_before = n_fail;
    for (int i = 0; i < SWEEP_N; i++) begin
      a = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      b = (i == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      want = 16'(a) * 16'(b);
      check("sweep_ready", 32'(s_in_ready[k]), 32'd1);
      s_in_valid[k] = 1'b1;
      tick();
      s_in_valid[k] = 1'b0;
      lat = 0;
      while (!s_out_valid[k] && lat < 20) begin
        tick();
        lat++;
      end
      check("sweep_latency", 32'(lat), 32'(8 >> k));
      check("sweep_p", 32'(s_p[k]), 32'(want));
      s_out_ready[k] = 1'b1;
      tick();
      s_out_ready[k] = 1'b0;
      check("sweep_idle", 32'({s_busy[k], s_out_valid[k]}), 32'd0);
    end
    check("sweep_err", 32'(s_err[k]), 32'd0);
    $display("sweep K=%0d pairs=%0d new_fails=%0d", 1 << k, SWEEP_N, n_fail - fails_before);
  endtask

  initial begin
    int guard;
    n_cmp = 0;
    n_fail = 0;
    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 0};
    vecs[1] = '{8'h00, 8'hA5, 16'h0000, 0};
    vecs[2] = '{8'h01, 8'h80, 16'h0080, 1};
    vecs[3] = '{8'h12, 8'h34, 16'h03A8, 5};
    vecs[4] = '{8'hF0, 8'h0F, 16'h0E10, 0};
    vecs[5] = '{8'h80, 8'h80, 16'h4000, 2};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF, 0};
    vecs[7] = '{8'h0D, 8'h0B, 16'h008F, 3};

    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 8'h55;
    b = 8'hAA;
    s_in_valid = '0;
    s_out_ready = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_outputs", 32'({out_valid, busy, err}), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    $display("reset done in_ready=%0d out_valid=%0d p=0x%0h", in_ready, out_valid, p);

    for (int i = 0; i < NVEC; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold);
    end

    // out_ready asserted while idle must not disturb anything.
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("idle_out_ready", 32'({in_ready, out_valid, busy}), 32'b100);

    // Reset two cycles into BUSY discards the product.
    a = 8'hF0;
    b = 8'h0F;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("midop_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midop_rst_state", 32'({in_ready, out_valid, busy, err}), 32'b1000);
    check("midop_rst_p", 32'(p), 32'd0);
    guard = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || busy) guard++;
    end
    check("midop_no_stale", 32'(guard), 32'd0);
    $display("midop reset: stale_cycles=%0d", guard);
    run_txn(8'h0F, 8'hF0, 16'h0E10, 1);

`ifdef MULT_SELFCHECK_EN
    begin
      logic [15:0] corrupt;
      a = 8'h33;
      b = 8'h11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      corrupt = dut.acc_d ^ 16'h0001;
      force dut.acc_d = corrupt;
      tick();
      release dut.acc_d;
      check("selfchk_err_set", 32'({out_valid, err}), 32'b11);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      check("selfchk_err_sticky", 32'(err), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("selfchk_err_rst", 32'(err), 32'd0);
      $display("selfcheck fault injection: err after rst=%0d", err);
    end
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    for (int k = 0; k < 4; k++) begin
      sweep(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
